env_evaporator: RTL and testbench
=================================

ENV_EVAPORATOR -- requirements
Module: env_evaporator

Interface
REQ-001 Parameter PIXELS_X, default 640: cells per row swept.
REQ-002 Parameter PIXELS_Y, default 480: rows swept.
REQ-003 Parameter X_bits / Y_bits / SIGNAL_bits, defaults 10 / 9 / 4: coordinate and signal widths, matching the environment store.
REQ-004 Parameter DECAY, default 1, width SIGNAL_bits: amount subtracted per sweep.
REQ-005 newLocClock  in  1  sole clock; all state updates on rising edge.
REQ-006 RESET_SIM  in  1  synchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to begin a full sweep.
REQ-008 bus_grant  in  1  environment write/lookup port granted to this block this cycle.
REQ-009 bus_req  out  1  high while a sweep is in progress and access is wanted.
REQ-010 lookup_X / lookup_Y  out  X_bits / Y_bits  cell address for reading.
REQ-011 lookup_signal / lookup_sugar  in  SIGNAL_bits / 1  combinational read data for the lookup address.
REQ-012 write_X / write_Y  out  X_bits / Y_bits  cell address for writing.
REQ-013 write_flag  out  1  write strobe; the store commits on the next edge.
REQ-014 write_signal / write_sugar  out  SIGNAL_bits / 1  write data.
REQ-015 busy  out  1  sweep in progress; done  out  1  one-cycle pulse at sweep completion.

Function
REQ-016 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-017 IDLE: start=1 -> READ, counters x=0, y=0; otherwise stay.
REQ-018 READ: bus_grant=1 -> latch sig=lookup_signal, sug=lookup_sugar, go WRITE; bus_grant=0 -> stay in READ.
REQ-019 WRITE with bus_grant=1: write_flag=1, write_X=x, write_Y=y, write_signal=sat(sig-DECAY), write_sugar=sug; then advance the counters.
REQ-020 WRITE with bus_grant=0: write_flag=0, no advance, return to READ (re-read, since the cell may have been written meanwhile).
REQ-021 Subtraction SHALL saturate at 0 (sig<DECAY -> 0); there is no wrap-around; sugar is passed through unmodified.
REQ-022 Advance: x increments; at x=PIXELS_X-1, x->0 and y increments; a write at (PIXELS_X-1, PIXELS_Y-1) -> DONE instead of READ.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 lookup_X/lookup_Y and write_X/write_Y SHALL equal counters x/y at all times.
REQ-025 write_flag SHALL be combinational: (state==WRITE) && bus_grant; it is never high in any other state.
REQ-026 bus_req and busy SHALL be high in READ and WRITE, low in IDLE and DONE.
REQ-027 start while not IDLE SHALL be ignored (no restart, no queuing).
REQ-028 With continuous grant, each cell SHALL take exactly 2 cycles; a sweep takes 2*PIXELS_X*PIXELS_Y cycles from the start edge to DONE entry.
REQ-029 Each cell SHALL be written exactly once per sweep, in row-major order (x fastest).

Reset
REQ-030 RESET_SIM=0 at an edge -> state IDLE, x=0, y=0, sig=0, sug=0; outputs bus_req=0, busy=0, done=0, write_flag=0, write/lookup addresses 0.
REQ-031 Reset mid-sweep SHALL abort without issuing any further write; reset has priority over start.

Verification (PIXELS_X=4, PIXELS_Y=3, DECAY=1)
REQ-032 All cells signal=5, sugar alternating, grant tied high, pulse start -> 12 writes at (0,0),(1,0)...(3,2), each signal=4 with sugar unchanged; done pulses 24 cycles after start.
REQ-033 Cells with signal 0 and 1, DECAY=2 -> both written back as 0, never 15/14.
REQ-034 Grant dropped for 3 cycles while in WRITE at (2,1), with a concurrent external write of 9 to that cell -> no write_flag while grant=0; the cell is re-read and written as 8.
REQ-035 Reset asserted at cell (1,1) -> next cycle write_flag=0, busy=0, address 0; a new start sweeps from (0,0).
REQ-036 start pulsed again mid-sweep -> exactly 12 writes total and a single done pulse.

Source files
------------

// File: rtl/env_evaporator_if.sv
// Environment-store access port shared by the evaporator (master) and the store (slave).
// Lookup data is combinational from the lookup address; writes commit on the next clock edge.
interface env_evaporator_if #(
    parameter int X_bits      = 10,
    parameter int Y_bits      = 9,
    parameter int SIGNAL_bits = 4
);
    logic                   bus_req;
    logic                   bus_grant;
    logic [X_bits-1:0]      lookup_X;
    logic [Y_bits-1:0]      lookup_Y;
    logic [SIGNAL_bits-1:0] lookup_signal;
    logic                   lookup_sugar;
    logic [X_bits-1:0]      write_X;
    logic [Y_bits-1:0]      write_Y;
    logic                   write_flag;
    logic [SIGNAL_bits-1:0] write_signal;
    logic                   write_sugar;

    modport master (
        output bus_req, lookup_X, lookup_Y, write_X, write_Y,
               write_flag, write_signal, write_sugar,
        input  bus_grant, lookup_signal, lookup_sugar
    );

    modport slave (
        input  bus_req, lookup_X, lookup_Y, write_X, write_Y,
               write_flag, write_signal, write_sugar,
        output bus_grant, lookup_signal, lookup_sugar
    );
endinterface

// File: rtl/env_evaporator.sv
// Sweeps every environment cell in row-major order, reading its signal and writing it back
// reduced by DECAY (floored at zero); sugar is carried through unchanged.
module env_evaporator #(
    parameter int                     PIXELS_X    = 640,
    parameter int                     PIXELS_Y    = 480,
    parameter int                     X_bits      = 10,
    parameter int                     Y_bits      = 9,
    parameter int                     SIGNAL_bits = 4,
    parameter logic [SIGNAL_bits-1:0] DECAY       = 1
) (
    input  logic              newLocClock,
    input  logic              RESET_SIM,
    input  logic              start,
    output logic              busy,
    output logic              done,
    env_evaporator_if.master  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [X_bits-1:0] X_LAST = X_bits'(PIXELS_X - 1);
    localparam logic [Y_bits-1:0] Y_LAST = Y_bits'(PIXELS_Y - 1);

    state_t                 state_q, state_d;
    logic [X_bits-1:0]      x_q, x_d;
    logic [Y_bits-1:0]      y_q, y_d;
    logic [SIGNAL_bits-1:0] sig_q, sig_d;
    logic                   sug_q, sug_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    function automatic logic [SIGNAL_bits-1:0] sat_sub(
        input logic [SIGNAL_bits-1:0] a,
        input logic [SIGNAL_bits-1:0] b
    );
        logic signed [SIGNAL_bits:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return (diff < 0) ? '0 : diff[SIGNAL_bits-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sig_d   = sig_q;
        sug_d   = sug_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            READ: begin
                if (bus.bus_grant) begin
                    sig_d   = bus.lookup_signal;
                    sug_d   = bus.lookup_sugar;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Losing the grant here means the cell may have changed: go back and re-read it.
                state_d = READ;
                if (bus.bus_grant) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = DONE;
                        end else begin
                            y_d = y_q + Y_bits'(1);
                        end
                    end else begin
                        x_d = x_q + X_bits'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == READ) || (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge newLocClock) begin
        if (!RESET_SIM) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sig_q   <= '0;
            sug_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sig_q   <= sig_d;
            sug_q   <= sug_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign bus.bus_req      = busy_q;
    assign bus.lookup_X     = x_q;
    assign bus.lookup_Y     = y_q;
    assign bus.write_X      = x_q;
    assign bus.write_Y      = y_q;
    assign bus.write_flag   = (state_q == WRITE) && bus.bus_grant;
    assign bus.write_signal = sat_sub(sig_q, DECAY);
    assign bus.write_sugar  = sug_q;
endmodule

// File: tb/tb_env_evaporator.sv
// Directed bench for env_evaporator on a 4x3 field: one store model per DUT instance
// (DECAY=1 and DECAY=2), each scenario checked inline in its own task.
module tb_env_evaporator;
    localparam int PX = 4;
    localparam int PY = 3;
    localparam int NC = PX * PY;

    logic clk = 1'b0;
    logic rst_n;
    logic start1, start2, grant1, grant2;
    logic busy1, done1, busy2, done2;
    logic load_en, ext_we;
    logic [3:0] ext_idx, ext_val;
    logic [3:0] ld_sig [16];
    logic       ld_sug [16];
    logic [3:0] mem1_sig [16];
    logic       mem1_sug [16];
    logic [3:0] mem2_sig [16];
    logic       mem2_sug [16];
    int         wcnt1 [16];
    int         wr_cnt1, wr_cnt2;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    env_evaporator_if #(.X_bits(10), .Y_bits(9), .SIGNAL_bits(4)) bus1 ();
    env_evaporator_if #(.X_bits(10), .Y_bits(9), .SIGNAL_bits(4)) bus2 ();

    env_evaporator #(.PIXELS_X(PX), .PIXELS_Y(PY), .X_bits(10), .Y_bits(9),
                     .SIGNAL_bits(4), .DECAY(4'd1)) dut1 (
        .newLocClock(clk), .RESET_SIM(rst_n), .start(start1),
        .busy(busy1), .done(done1), .bus(bus1));

    env_evaporator #(.PIXELS_X(PX), .PIXELS_Y(PY), .X_bits(10), .Y_bits(9),
                     .SIGNAL_bits(4), .DECAY(4'd2)) dut2 (
        .newLocClock(clk), .RESET_SIM(rst_n), .start(start2),
        .busy(busy2), .done(done2), .bus(bus2));

    logic [3:0] lidx1, widx1, lidx2, widx2;
    assign lidx1 = 4'(int'(bus1.lookup_Y) * PX + int'(bus1.lookup_X));
    assign widx1 = 4'(int'(bus1.write_Y) * PX + int'(bus1.write_X));
    assign lidx2 = 4'(int'(bus2.lookup_Y) * PX + int'(bus2.lookup_X));
    assign widx2 = 4'(int'(bus2.write_Y) * PX + int'(bus2.write_X));
    assign bus1.bus_grant     = grant1;
    assign bus1.lookup_signal = mem1_sig[lidx1];
    assign bus1.lookup_sugar  = mem1_sug[lidx1];
    assign bus2.bus_grant     = grant2;
    assign bus2.lookup_signal = mem2_sig[lidx2];
    assign bus2.lookup_sugar  = mem2_sug[lidx2];

    // Environment store model: loads, DUT write-backs and one external writer.
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 16; i++) begin
                mem1_sig[i] <= ld_sig[i];
                mem1_sug[i] <= ld_sug[i];
                mem2_sig[i] <= ld_sig[i];
                mem2_sug[i] <= ld_sug[i];
                wcnt1[i]    <= 0;
            end
            wr_cnt1 <= 0;
            wr_cnt2 <= 0;
        end else begin
            if (bus1.write_flag) begin
                mem1_sig[widx1] <= bus1.write_signal;
                mem1_sug[widx1] <= bus1.write_sugar;
                wcnt1[widx1]    <= wcnt1[widx1] + 1;
                wr_cnt1         <= wr_cnt1 + 1;
            end
            if (ext_we) mem1_sig[ext_idx] <= ext_val;
            if (bus2.write_flag) begin
                mem2_sig[widx2] <= bus2.write_signal;
                mem2_sug[widx2] <= bus2.write_sugar;
                wr_cnt2         <= wr_cnt2 + 1;
            end
        end
    end

    task automatic load_cells(input int mode);
        for (int i = 0; i < 16; i++) begin
            ld_sig[i] = (mode == 0) ? 4'd5 : 4'(i % 4);
            ld_sug[i] = (mode == 0) ? 1'(i % 2) : 1'b1;
        end
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start1 = 1'b1; start2 = 1'b0; grant1 = 1'b1; grant2 = 1'b1;
        ext_we = 1'b0; ext_idx = '0; ext_val = '0; load_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy1, done1, bus1.bus_req, bus1.write_flag} !== 4'b0000)
            begin errors++; $display("FAIL reset_ctrl got %b want 0000", {busy1, done1, bus1.bus_req, bus1.write_flag}); end
        checks++;
        if ({bus1.write_X, bus1.write_Y, bus1.lookup_X, bus1.lookup_Y} !== 38'd0)
            begin errors++; $display("FAIL reset_addr got %h want 0", {bus1.write_X, bus1.write_Y, bus1.lookup_X, bus1.lookup_Y}); end
        start1 = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy1); end
    endtask

    task automatic test_sweep;
        logic exp_wf;
        int   k;
        load_cells(0);
        start1 = 1'b1;
        for (int t = 0; t <= 26; t++) begin
            @(negedge clk);
            if (t == 0) start1 = 1'b0;
            exp_wf = (t % 2 == 1) && (t <= 23);
            k      = (t - 1) / 2;
            checks++;
            if (bus1.write_flag !== exp_wf) begin errors++; $display("FAIL sweep_wf t=%0d got %b want %b", t, bus1.write_flag, exp_wf); end
            if (exp_wf) begin
                checks++;
                if ({bus1.write_X, bus1.write_Y, bus1.lookup_X, bus1.lookup_Y} !== {10'(k % 4), 9'(k / 4), 10'(k % 4), 9'(k / 4)})
                    begin errors++; $display("FAIL sweep_addr k=%0d got (%0d,%0d) want (%0d,%0d)", k, bus1.write_X, bus1.write_Y, k % 4, k / 4); end
                checks++;
                if ({bus1.write_signal, bus1.write_sugar} !== {4'd4, 1'(k % 2)})
                    begin errors++; $display("FAIL sweep_data k=%0d got %0d/%b want 4/%b", k, bus1.write_signal, bus1.write_sugar, 1'(k % 2)); end
            end
            checks++;
            if (done1 !== (t == 24)) begin errors++; $display("FAIL sweep_done t=%0d got %b", t, done1); end
            checks++;
            if ({busy1, bus1.bus_req} !== {2{t <= 23}}) begin errors++; $display("FAIL sweep_busy t=%0d got %b", t, {busy1, bus1.bus_req}); end
        end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if ({mem1_sig[i], mem1_sug[i]} !== {4'd4, 1'(i % 2)} || wcnt1[i] !== 1)
                begin errors++; $display("FAIL sweep_cell %0d got %0d/%b x%0d want 4/%b x1", i, mem1_sig[i], mem1_sug[i], wcnt1[i], 1'(i % 2)); end
        end
    endtask

    task automatic test_saturate;
        logic [3:0] exp_sat [4];
        int k;
        exp_sat[0] = 4'd0; exp_sat[1] = 4'd0; exp_sat[2] = 4'd0; exp_sat[3] = 4'd1;
        load_cells(1);
        start2 = 1'b1;
        for (int t = 0; t <= 25; t++) begin
            @(negedge clk);
            if (t == 0) start2 = 1'b0;
            k = (t - 1) / 2;
            if (t % 2 == 1 && t <= 23) begin
                checks++;
                if (bus2.write_flag !== 1'b1 || bus2.write_signal !== exp_sat[k % 4])
                    begin errors++; $display("FAIL sat_write k=%0d got wf=%b sig=%0d want 1/%0d", k, bus2.write_flag, bus2.write_signal, exp_sat[k % 4]); end
            end
            if (t == 24) begin
                checks++;
                if (done2 !== 1'b1) begin errors++; $display("FAIL sat_done got %b want 1", done2); end
            end
        end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if ({mem2_sig[i], mem2_sug[i]} !== {exp_sat[i % 4], 1'b1})
                begin errors++; $display("FAIL sat_cell %0d got %0d/%b want %0d/1", i, mem2_sig[i], mem2_sug[i], exp_sat[i % 4]); end
        end
        checks++;
        if (wr_cnt2 !== NC) begin errors++; $display("FAIL sat_count got %0d want %0d", wr_cnt2, NC); end
    endtask

    task automatic test_grant_drop;
        int n;
        load_cells(0);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (n = 0; n < 40 && !(bus1.write_flag && bus1.write_X == 10'd2 && bus1.write_Y == 9'd1); n++)
            @(negedge clk);
        checks++;
        if (n >= 40) begin errors++; $display("FAIL drop_reach got timeout want write at (2,1)"); end
        grant1 = 1'b0;
        #1;
        checks++;
        if (bus1.write_flag !== 1'b0) begin errors++; $display("FAIL drop_wf0 got %b want 0", bus1.write_flag); end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin ext_we = 1'b1; ext_idx = 4'd6; ext_val = 4'd9; end
            @(negedge clk);
            ext_we = 1'b0;
            checks++;
            if ({bus1.write_flag, busy1} !== 2'b01) begin errors++; $display("FAIL drop_hold%0d got wf/busy %b want 01", i, {bus1.write_flag, busy1}); end
        end
        grant1 = 1'b1;
        @(negedge clk);
        checks++;
        if (bus1.write_flag !== 1'b1 || bus1.write_X !== 10'd2 || bus1.write_Y !== 9'd1 || bus1.write_signal !== 4'd8)
            begin errors++; $display("FAIL drop_rewrite got wf=%b (%0d,%0d) sig=%0d want 1 (2,1) 8", bus1.write_flag, bus1.write_X, bus1.write_Y, bus1.write_signal); end
        for (n = 0; n < 40 && !done1; n++) @(negedge clk);
        checks++;
        if (n >= 40) begin errors++; $display("FAIL drop_done got timeout want done"); end
        checks++;
        if (mem1_sig[6] !== 4'd8 || wcnt1[6] !== 1) begin errors++; $display("FAIL drop_cell got %0d x%0d want 8 x1", mem1_sig[6], wcnt1[6]); end
        checks++;
        if (wr_cnt1 !== NC || mem1_sig[5] !== 4'd4) begin errors++; $display("FAIL drop_total got %0d writes cell5=%0d want 12, 4", wr_cnt1, mem1_sig[5]); end
    endtask

    task automatic test_reset_mid;
        int n;
        load_cells(0);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (n = 0; n < 40 && !(busy1 && !bus1.write_flag && bus1.lookup_X == 10'd1 && bus1.lookup_Y == 9'd1); n++)
            @(negedge clk);
        checks++;
        if (n >= 40) begin errors++; $display("FAIL rmid_reach got timeout want read at (1,1)"); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus1.write_flag, busy1, bus1.bus_req} !== 3'b000 || {bus1.write_X, bus1.write_Y} !== 19'd0)
            begin errors++; $display("FAIL rmid_abort got wf/busy/req %b addr (%0d,%0d) want 000 (0,0)", {bus1.write_flag, busy1, bus1.bus_req}, bus1.write_X, bus1.write_Y); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt1 !== 5 || busy1 !== 1'b0) begin errors++; $display("FAIL rmid_nowrite got %0d writes busy %b want 5, 0", wr_cnt1, busy1); end
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (n = 0; n < 10 && !bus1.write_flag; n++) @(negedge clk);
        checks++;
        if (n >= 10 || bus1.write_X !== 10'd0 || bus1.write_Y !== 9'd0)
            begin errors++; $display("FAIL rmid_restart got (%0d,%0d) wait %0d want (0,0)", bus1.write_X, bus1.write_Y, n); end
        for (n = 0; n < 40 && !done1; n++) @(negedge clk);
        checks++;
        if (n >= 40 || wr_cnt1 !== 17) begin errors++; $display("FAIL rmid_finish got %0d writes want 17", wr_cnt1); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int ndone, done_t;
        load_cells(0);
        ndone = 0; done_t = -1;
        start1 = 1'b1;
        for (int t = 0; t <= 30; t++) begin
            @(negedge clk);
            start1 = (t == 10) || (t == 24);
            if (done1) begin ndone++; done_t = t; end
        end
        start1 = 1'b0;
        checks++;
        if (ndone !== 1 || done_t !== 24) begin errors++; $display("FAIL b2b_done got %0d pulses at t=%0d want 1 at 24", ndone, done_t); end
        checks++;
        if (wr_cnt1 !== NC) begin errors++; $display("FAIL b2b_count got %0d want %0d", wr_cnt1, NC); end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy %b want 0", busy1); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_saturate();
        test_grant_drop();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
